// File: rtl/ring_pkg.sv
// ring_pkg: shared definitions for the ring NIC host controller.
//   - NIC register select codes (INPUT_BUFFER .. OUTPUT_STATUS)
//   - big-endian [0:63] packet field index ranges
//   - controller FSM state and round-robin owner types
//   - hop_therm(): hop count -> thermometer-coded hop field
package ring_pkg;

  localparam logic [1:0] INPUT_BUFFER  = 2'b00;
  localparam logic [1:0] INPUT_STATUS  = 2'b01;
  localparam logic [1:0] OUTPUT_BUFFER = 2'b10;
  localparam logic [1:0] OUTPUT_STATUS = 2'b11;

  localparam int PKT_W    = 64;
  localparam int VC_BIT   = 0;
  localparam int DIR_BIT  = 1;
  localparam int RSV_LO   = 2;
  localparam int RSV_HI   = 7;
  localparam int HOP_LO   = 8;
  localparam int HOP_HI   = 15;
  localparam int SRC_LO   = 16;
  localparam int SRC_HI   = 31;
  localparam int PAY_LO   = 32;
  localparam int PAY_HI   = 63;
  // Status words report buffer occupancy in their last bit.
  localparam int STAT_BIT = 63;

  typedef enum logic [2:0] {
    IDLE,
    OUT_STAT,
    OUT_CHK,
    OUT_WR,
    IN_STAT,
    IN_CHK,
    IN_RD,
    IN_CAP
  } state_t;

  typedef enum logic {
    RR_TX = 1'b0,
    RR_RX = 1'b1
  } rr_t;

  // count ones packed from the LSB: 1 -> 8'h01, 2 -> 8'h03 (valid for 0..8).
  function automatic logic [7:0] hop_therm(input logic [3:0] count);
    logic [8:0] one_hot;
    one_hot = 9'd1 << count;
    return 8'(one_hot - 9'd1);
  endfunction

endpackage

// File: rtl/ring_pkt_builder.sv
// ring_pkt_builder: combinational ring packet header builder.
// Ports:
//   dst       in  2   destination node id
//   payload   in  32  data for packet bits [32:63]
//   pkt       out 64  big-endian packet {vc, dir, rsv, hop, source, payload}
//   self_dest out 1   dst equals this node; the packet must not be sent
import ring_pkg::*;

module ring_pkt_builder #(
  parameter logic [1:0] NODE_ID   = 2'd0,
  parameter int         NUM_NODES = 4
) (
  input  logic [1:0]  dst,
  input  logic [31:0] payload,
  output logic [0:63] pkt,
  output logic        self_dest
);

  localparam int SRC  = int'(NODE_ID);
  localparam int PREV = (SRC + NUM_NODES - 1) % NUM_NODES;

  int         dst_i;
  int         fwd;
  int         bwd;
  logic       dir;
  logic [3:0] hops;

  always_comb begin
    dst_i = int'({30'd0, dst});
    fwd   = (dst_i - SRC + NUM_NODES) % NUM_NODES;
    bwd   = (SRC - dst_i + NUM_NODES) % NUM_NODES;
    // Only the immediate upstream neighbour is reached by going backwards;
    // everything else travels forward around the ring.
    dir   = (dst_i == PREV);
    hops  = dir ? 4'(bwd) : 4'(fwd);

    pkt                  = '0;
    pkt[VC_BIT]          = NODE_ID[1];
    pkt[DIR_BIT]         = dir;
    pkt[HOP_LO:HOP_HI]   = hop_therm(hops);
    pkt[SRC_LO:SRC_HI]   = {14'd0, NODE_ID};
    pkt[PAY_LO:PAY_HI]   = payload;
  end

  assign self_dest = (dst == NODE_ID);

endmodule

// File: rtl/nic_host_ctrl.sv
// nic_host_ctrl: host-side sequencer for one ring NIC.
// Converts a tx request/ack handshake and an rx ready/valid handshake into
// NIC status-poll, buffer-write and buffer-read sequences, arbitrating
// round-robin between transmit and receive work.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   tx_req/tx_dst/tx_payload  send request, held stable until tx_ack
//   tx_ack, tx_err        1-cycle completion pulse; tx_err = self-addressed drop
//   rx_ready              sink can take a packet (sampled in IDLE only)
//   rx_valid, rx_data     1-cycle pulse with the fetched packet
//   addr, d_in, nicEn, nicWrEn  NIC register port (registered outputs)
//   d_out                 NIC read data, valid the cycle after a read
import ring_pkg::*;

module nic_host_ctrl #(
  parameter logic [1:0] NODE_ID   = 2'd0,
  parameter int         NUM_NODES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_req,
  input  logic [1:0]  tx_dst,
  input  logic [31:0] tx_payload,
  output logic        tx_ack,
  output logic        tx_err,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [0:63] rx_data,
  output logic [0:1]  addr,
  output logic [0:63] d_in,
  input  logic [0:63] d_out,
  output logic        nicEn,
  output logic        nicWrEn
);

  state_t      state;
  rr_t         rr_last;
  logic        tx_ack_q;
  logic [0:63] pkt;
  logic        self_dest;
  logic        cand_tx;
  logic        cand_rx;
  logic        pick_tx;
  logic        pick_rx;

  ring_pkt_builder #(
    .NODE_ID   (NODE_ID),
    .NUM_NODES (NUM_NODES)
  ) u_builder (
    .dst       (tx_dst),
    .payload   (tx_payload),
    .pkt       (pkt),
    .self_dest (self_dest)
  );

  // A request is blocked while its ack is showing and for one cycle after,
  // so the requester has time to drop or change it.
  assign cand_tx = tx_req & ~tx_ack & ~tx_ack_q;
  assign cand_rx = rx_ready;
  assign pick_tx = cand_tx & (~cand_rx | (rr_last == RR_RX));
  assign pick_rx = cand_rx & ~pick_tx;

  // NIC outputs are loaded on the edge that enters a state, so they are a
  // registered decode of the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_last  <= RR_RX;
      tx_ack   <= 1'b0;
      tx_err   <= 1'b0;
      tx_ack_q <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      addr     <= '0;
      d_in     <= '0;
      nicEn    <= 1'b0;
      nicWrEn  <= 1'b0;
    end else begin
      tx_ack_q <= tx_ack;
      tx_ack   <= 1'b0;
      tx_err   <= 1'b0;
      rx_valid <= 1'b0;
      nicEn    <= 1'b0;
      nicWrEn  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_tx) begin
            if (self_dest) begin
              tx_ack  <= 1'b1;
              tx_err  <= 1'b1;
              rr_last <= RR_TX;
            end else begin
              state <= OUT_STAT;
              addr  <= OUTPUT_STATUS;
              nicEn <= 1'b1;
            end
          end else if (pick_rx) begin
            state <= IN_STAT;
            addr  <= INPUT_STATUS;
            nicEn <= 1'b1;
          end
        end
        OUT_STAT: state <= OUT_CHK;
        OUT_CHK: begin
          if (!d_out[STAT_BIT]) begin
            state   <= OUT_WR;
            addr    <= OUTPUT_BUFFER;
            nicEn   <= 1'b1;
            nicWrEn <= 1'b1;
            d_in    <= pkt;
            tx_ack  <= 1'b1;
          end else begin
            // Output buffer still occupied: give the other side a turn.
            state   <= IDLE;
            rr_last <= RR_TX;
          end
        end
        OUT_WR: begin
          state   <= IDLE;
          rr_last <= RR_TX;
        end
        IN_STAT: state <= IN_CHK;
        IN_CHK: begin
          if (d_out[STAT_BIT]) begin
            state <= IN_RD;
            addr  <= INPUT_BUFFER;
            nicEn <= 1'b1;
          end else begin
            state   <= IDLE;
            rr_last <= RR_RX;
          end
        end
        IN_RD: state <= IN_CAP;
        IN_CAP: begin
          rx_data  <= d_out;
          rx_valid <= 1'b1;
          state    <= IDLE;
          rr_last  <= RR_RX;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nic_host_ctrl.sv
// tb_nic_host_ctrl: directed bench for nic_host_ctrl.
// Two instances (NODE_ID 0 and 2) share the request inputs; node 0 talks to a
// small behavioural NIC, node 2 sees an always-empty NIC and is used for
// header-format checks.
module tb_nic_host_ctrl;

  localparam byte EV_TX = 8'd84;
  localparam byte EV_RX = 8'd82;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_req;
  logic [1:0]  tx_dst;
  logic [31:0] tx_payload;
  logic        rx_ready;

  logic        tx_ack0, tx_err0, rx_valid0, nic_en0, nic_wr_en0;
  logic [0:63] rx_data0, d_in0;
  logic [0:1]  addr0;
  logic [0:63] d_out0 = '0;

  logic        tx_ack2, tx_err2, rx_valid2, nic_en2, nic_wr_en2;
  logic [0:63] rx_data2, d_in2;
  logic [0:1]  addr2;
  logic [0:63] d_out2;

  // NIC model configuration
  logic        in_full;
  logic [0:63] in_buf;
  int          busy_until;

  // monitors
  int          cyc = 0;
  int          opoll0 = 0, wr0 = 0, wen0 = 0, en0 = 0, ack0 = 0, bad_we0 = 0;
  int          wr2 = 0;
  logic [0:63] last_wr0 = '0, last_wr2 = '0, last_rx0 = '0;
  byte         log_kind[$];
  int          log_cyc[$];

  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign d_out2 = '0;

  nic_host_ctrl #(.NODE_ID(2'd0), .NUM_NODES(4)) u0 (
    .clk(clk), .reset(reset), .tx_req(tx_req), .tx_dst(tx_dst),
    .tx_payload(tx_payload), .tx_ack(tx_ack0), .tx_err(tx_err0),
    .rx_ready(rx_ready), .rx_valid(rx_valid0), .rx_data(rx_data0),
    .addr(addr0), .d_in(d_in0), .d_out(d_out0), .nicEn(nic_en0),
    .nicWrEn(nic_wr_en0)
  );

  nic_host_ctrl #(.NODE_ID(2'd2), .NUM_NODES(4)) u2 (
    .clk(clk), .reset(reset), .tx_req(tx_req), .tx_dst(tx_dst),
    .tx_payload(tx_payload), .tx_ack(tx_ack2), .tx_err(tx_err2),
    .rx_ready(rx_ready), .rx_valid(rx_valid2), .rx_data(rx_data2),
    .addr(addr2), .d_in(d_in2), .d_out(d_out2), .nicEn(nic_en2),
    .nicWrEn(nic_wr_en2)
  );

  // Behavioural NIC for node 0 plus event monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (nic_en0 && !nic_wr_en0) begin
      case (addr0)
        2'b00:   d_out0 <= in_buf;
        2'b01:   d_out0 <= {63'd0, in_full};
        2'b11:   d_out0 <= {63'd0, (opoll0 < busy_until)};
        default: d_out0 <= '0;
      endcase
      if (addr0 == 2'b11) opoll0 <= opoll0 + 1;
    end
    if (nic_en0 && nic_wr_en0 && addr0 == 2'b10) begin
      wr0      <= wr0 + 1;
      last_wr0 <= d_in0;
    end
    if (nic_wr_en0) wen0 <= wen0 + 1;
    if (nic_wr_en0 && !nic_en0) bad_we0 <= bad_we0 + 1;
    if (nic_en0) en0 <= en0 + 1;
    if (tx_ack0) begin
      ack0 <= ack0 + 1;
      log_kind.push_back(EV_TX);
      log_cyc.push_back(cyc);
    end
    if (rx_valid0) begin
      last_rx0 <= rx_data0;
      log_kind.push_back(EV_RX);
      log_cyc.push_back(cyc);
    end
    if (nic_en2 && nic_wr_en2 && addr2 == 2'b10) begin
      wr2      <= wr2 + 1;
      last_wr2 <= d_in2;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack0(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (tx_ack0) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int e0, a0, w0, p0, we_b;
    int base;
    int found;

    reset = 1'b1; tx_req = 1'b0; tx_dst = 2'd0; tx_payload = '0;
    rx_ready = 1'b0; in_full = 1'b0; in_buf = '0; busy_until = 0;
    repeat (3) tick();
    check("rst_ctrl", {tx_ack0, tx_err0, rx_valid0, nic_en0, nic_wr_en0, addr0}, 0);
    check("rst_din", d_in0, 0);
    check("rst_rx_data", rx_data0, 0);
    reset = 1'b0;
    tick();

    // basic transmit, output buffer empty
    a0 = ack0;
    tx_dst = 2'd1; tx_payload = 32'hDEADBEEF; tx_req = 1'b1;
    wait_ack0(20, lat);
    check("t1_latency", lat, 3);
    check("t1_en_wren", {nic_en0, nic_wr_en0}, 2'b11);
    check("t1_addr", addr0, 2'b10);
    check("t1_err", tx_err0, 0);
    check("t1_pkt_n0", d_in0, 64'h0001_0000_DEADBEEF);
    tx_req = 1'b0;
    repeat (4) tick();
    check("t1_din_held", d_in0, 64'h0001_0000_DEADBEEF);
    check("t1_ack_once", ack0 - a0, 1);
    check("t1_pkt_n2", last_wr2, 64'hC001_0002_DEADBEEF);

    // self-addressed on node 0, dir0/two-hop header on node 2
    e0 = en0;
    tx_dst = 2'd0; tx_payload = 32'h12345678; tx_req = 1'b1;
    tick();
    check("t2_self_ack_err", {tx_ack0, tx_err0}, 2'b11);
    tx_req = 1'b0;
    tick();
    check("t2_ack_pulse", {tx_ack0, tx_err0}, 2'b00);
    repeat (4) tick();
    check("t2_no_nic_en", en0 - e0, 0);
    check("t2_pkt_n2", last_wr2, 64'h8003_0002_12345678);

    // output buffer busy on three polls
    busy_until = opoll0 + 3;
    p0 = opoll0; w0 = wr0; we_b = wen0; a0 = ack0;
    tx_dst = 2'd3; tx_payload = 32'hA5A5A5A5; tx_req = 1'b1;
    wait_ack0(60, lat);
    tx_req = 1'b0;
    check("t3_latency", lat, 12);
    repeat (4) tick();
    check("t3_polls", opoll0 - p0, 4);
    check("t3_writes", wr0 - w0, 1);
    check("t3_wren_cycles", wen0 - we_b, 1);
    check("t3_acks", ack0 - a0, 1);
    check("t3_pkt", last_wr0, 64'h4001_0000_A5A5A5A5);

    // reset during OUT_CHK, then re-present
    a0 = ack0; w0 = wr0;
    tx_dst = 2'd2; tx_payload = 32'h0BADF00D; tx_req = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (nic_en0 && addr0 == 2'b11) begin
        found = 1;
        break;
      end
    end
    check("t6_saw_out_stat", found, 1);
    tick();
    reset = 1'b1;
    tick();
    check("t6_after_rst", {nic_en0, nic_wr_en0, tx_ack0}, 0);
    check("t6_din_rst", d_in0, 0);
    check("t6_no_write", wr0 - w0, 0);
    reset = 1'b0;
    wait_ack0(20, lat);
    check("t6_relatency", lat, 3);
    tx_req = 1'b0;
    repeat (3) tick();
    check("t6_one_write", wr0 - w0, 1);
    check("t6_pkt", last_wr0, 64'h0003_0000_0BADF00D);

    // round-robin with both sides pending, input buffer full
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    in_full = 1'b1; in_buf = 64'h0123_4567_89AB_CDEF;
    base = log_kind.size();
    tx_dst = 2'd1; tx_payload = 32'h11112222; tx_req = 1'b1; rx_ready = 1'b1;
    for (int i = 0; i < 80 && log_kind.size() < base + 3; i++) begin
      tick();
      if (log_kind.size() == base + 1) tx_payload = 32'h33334444;
    end
    tx_req = 1'b0; rx_ready = 1'b0;
    repeat (6) tick();
    check("t4_event_count", log_kind.size() - base, 3);
    if (log_kind.size() >= base + 3) begin
      check("t4_first_tx", log_kind[base], EV_TX);
      check("t4_second_rx", log_kind[base+1], EV_RX);
      check("t4_third_tx", log_kind[base+2], EV_TX);
      check("t4_tx_to_rx", log_cyc[base+1] - log_cyc[base], 6);
      check("t4_rx_to_tx", log_cyc[base+2] - log_cyc[base+1], 3);
    end
    check("t4_rx_data", last_rx0, 64'h0123_4567_89AB_CDEF);
    check("t4_pkt2", last_wr0, 64'h0001_0000_3333_4444);
    check("no_wren_without_en", bad_we0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
